// File: rtl/mem_readout.sv
// mem_readout: streams the entries of the memory page completed in the previous BX.
// On each new-BX strobe, the page (BX counter before increment) is read from a
// 2-cycle-latency memory. Reads are paced by a credit rule so returning words always
// fit the skid FIFO, and the FIFO feeds a valid/ready output. The last word of a
// page is flagged with last_out.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   start      [1] synchronous flush, [0] new-BX strobe
//   done       start delayed by 3 clk
//   number_in  valid-entry count of the page just completed
//   read_add   memory read address {page[4:0], entry}
//   data_in    memory read data, valid 2 clk after read_add
//   data_out   streamed word (FIFO head)
//   valid_out  data_out holds a word
//   ready_in   downstream accepts
//   last_out   data_out is the final word of the page
//   truncated  one-clk pulse when a readout is cut short by a new start[0]
module mem_readout #(
  parameter int unsigned INPUT_SIZE = 18,
  parameter int unsigned MEM_SIZE   = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            start,
  output logic [1:0]            done,
  input  logic [5:0]            number_in,
  output logic [MEM_SIZE+4:0]   read_add,
  input  logic [INPUT_SIZE-1:0] data_in,
  output logic [INPUT_SIZE-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic                  truncated
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned OW   = PW + 1;
  localparam int unsigned CW   = MEM_SIZE + 1;
  localparam int unsigned NMAX = 1 << MEM_SIZE;
  localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            bx_q, bx_d;
  logic [4:0]            page_q, page_d;
  logic [CW-1:0]         n_q, n_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [4:0]            pend_page_q, pend_page_d;
  logic [CW-1:0]         pend_n_q, pend_n_d;
  logic [MEM_SIZE+4:0]   read_add_q, read_add_d;
  logic                  trunc_q, trunc_d;
  // Issued-read tracker: stage 0 = address presented, stage 2 = data_in valid now.
  logic [2:0]            pv_q, pv_d;
  logic [2:0]            pl_q, pl_d;
  logic [FIFO_DEPTH-1:0] lm_q, lm_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [1:0]            dly1_q, dly2_q, dly3_q;
  logic [INPUT_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic          valid, pop, push, push_last, drained, issue_ok, retag_fifo, last_issue;
  logic [CW-1:0] n_clip;
  logic [OW-1:0] used;

  assign valid   = (occ_q != '0);
  assign pop     = valid & ready_in;
  assign push    = pv_q[2];
  assign drained = (occ_q == '0) && (pv_q == '0);
  // A pop in this cycle frees a slot, so issuing continues at full rate under ready_in.
  assign used     = occ_q + OW'(pv_q[0]) + OW'(pv_q[1]) + OW'(pv_q[2]) - OW'(pop);
  assign issue_ok = (used < DEPTH_C);
  assign last_issue = (cnt_q == (n_q - CW'(1)));

  always_comb begin
    if (32'(number_in) > NMAX) n_clip = CW'(NMAX);
    else                       n_clip = CW'(number_in);
  end

  always_comb begin
    state_d     = state_q;
    bx_d        = bx_q;
    page_d      = page_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_page_d = pend_page_q;
    pend_n_d    = pend_n_q;
    read_add_d  = read_add_q;
    trunc_d     = 1'b0;
    pv_d        = {pv_q[1:0], 1'b0};
    pl_d        = {pl_q[1:0], 1'b0};
    push_last   = pl_q[2];
    retag_fifo  = 1'b0;
    lm_d        = lm_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    occ_d       = occ_q;

    if (start[0]) bx_d = bx_q + 5'd1;

    case (state_q)
      IDLE: begin
        if (start[0] && (n_clip != '0)) begin
          state_d = READ;
          page_d  = bx_q;
          n_d     = n_clip;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (start[0]) begin
          trunc_d     = 1'b1;
          state_d     = DRAIN;
          pend_d      = (n_clip != '0);
          pend_page_d = bx_q;
          pend_n_d    = n_clip;
          // Move the last flag onto the youngest issued word, wherever it now sits.
          if (cnt_q != '0) begin
            if      (pv_q[0]) pl_d[1]    = 1'b1;
            else if (pv_q[1]) pl_d[2]    = 1'b1;
            else if (pv_q[2]) push_last  = 1'b1;
            else              retag_fifo = 1'b1;
          end
        end else if (issue_ok) begin
          read_add_d = {page_q, cnt_q[MEM_SIZE-1:0]};
          pv_d[0]    = 1'b1;
          pl_d[0]    = last_issue;
          cnt_d      = cnt_q + CW'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          pend_d = 1'b0;
          if (start[0]) begin
            if (n_clip != '0) begin
              state_d = READ;
              page_d  = bx_q;
              n_d     = n_clip;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else if (pend_q) begin
            state_d = READ;
            page_d  = pend_page_q;
            n_d     = pend_n_q;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (start[0]) begin
          pend_d      = (n_clip != '0);
          pend_page_d = bx_q;
          pend_n_d    = n_clip;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      lm_d[wr_q] = push_last;
      wr_d       = wr_q + PW'(1);
    end
    if (retag_fifo) lm_d[wr_q - PW'(1)] = 1'b1;
    if (pop) rd_d = rd_q + PW'(1);
    occ_d = occ_q + OW'(push) - OW'(pop);

    if (start[1]) begin
      state_d    = IDLE;
      bx_d       = '1;
      pend_d     = 1'b0;
      pv_d       = '0;
      pl_d       = '0;
      lm_d       = '0;
      wr_d       = '0;
      rd_d       = '0;
      occ_d      = '0;
      trunc_d    = 1'b0;
      read_add_d = read_add_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bx_q        <= '1;
      page_q      <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_page_q <= '0;
      pend_n_q    <= '0;
      read_add_q  <= '0;
      trunc_q     <= 1'b0;
      pv_q        <= '0;
      pl_q        <= '0;
      lm_q        <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      occ_q       <= '0;
      dly1_q      <= '0;
      dly2_q      <= '0;
      dly3_q      <= '0;
    end else begin
      state_q     <= state_d;
      bx_q        <= bx_d;
      page_q      <= page_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_page_q <= pend_page_d;
      pend_n_q    <= pend_n_d;
      read_add_q  <= read_add_d;
      trunc_q     <= trunc_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      lm_q        <= lm_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      occ_q       <= occ_d;
      dly1_q      <= start;
      dly2_q      <= dly1_q;
      dly3_q      <= dly2_q;
    end
  end

  // FIFO storage needs no reset: data_out is gated by valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data_in;
  end

  assign valid_out = valid;
  assign data_out  = valid ? mem_q[rd_q] : '0;
  assign last_out  = valid & lm_q[rd_q];
  assign read_add  = read_add_q;
  assign truncated = trunc_q;
  assign done      = dly3_q;

endmodule

// File: tb/tb_mem_readout.sv
// Testbench for mem_readout: 2-cycle-latency memory model, scoreboard of expected
// words pushed at each start and popped on every output transfer.
module tb_mem_readout;
  localparam int unsigned IW = 18;
  localparam int unsigned MS = 6;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    start = 2'b00;
  logic [1:0]    done;
  logic [5:0]    number_in = 6'd0;
  logic [MS+4:0] read_add;
  logic [IW-1:0] data_in = '0;
  logic [IW-1:0] data_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic          last_out;
  logic          truncated;
  logic [MS+4:0] addr_r = '0;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_xfer = 0;

  typedef struct packed {
    logic [IW-1:0] data;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_readout #(.INPUT_SIZE(IW), .MEM_SIZE(MS), .FIFO_DEPTH(FD)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .number_in(number_in),
    .read_add (read_add),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .last_out (last_out),
    .truncated(truncated)
  );

  function automatic logic [MS+4:0] addr_of(input logic [4:0] page, input int unsigned e);
    return {page, MS'(e)};
  endfunction

  function automatic logic [IW-1:0] word_of_addr(input logic [MS+4:0] a);
    return (IW'(a) * IW'(37)) ^ IW'(18'h2B5C3);
  endfunction

  // Memory: address registered, then data registered (2 clk latency).
  always @(posedge clk) begin
    addr_r  <= read_add;
    data_in <= word_of_addr(addr_r);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_page(input logic [4:0] page, input int unsigned n);
    exp_t x;
    for (int unsigned e = 0; e < n; e++) begin
      x.data = word_of_addr(addr_of(page, e));
      x.last = (e == n - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_empty(input int unsigned maxc, input string tag);
    int unsigned c;
    c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      tick();
      c++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_valid"}, 32'(valid_out), 32'd0);
    check({tag, "_last"},  32'(last_out),  32'd0);
    check({tag, "_trunc"}, 32'(truncated), 32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_addr"},  32'(read_add),  32'd0);
    check({tag, "_data"},  32'(data_out),  32'd0);
  endtask

  // Output monitor: every transfer must match the scoreboard head.
  always @(negedge clk) begin
    exp_t x;
    if (reset && valid_out && ready_in) begin
      check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("xfer_data", 32'(data_out), 32'(x.data));
        check("xfer_last", 32'(last_out), 32'(x.last));
        n_xfer++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MS+4:0] prev;
    int unsigned   changes;

    // Reset state
    repeat (3) tick();
    check_rst("rst");
    reset = 1'b1;
    tick();
    check("rst_exit_valid", 32'(valid_out), 32'd0);

    // A: 5 entries of page 31, ready high
    n_xfer = 0; ready_in = 1'b1; number_in = 6'd5; start = 2'b01;
    expect_page(5'd31, 5);
    tick();
    start = 2'b00;
    check("A_addr_hold", 32'(read_add), 32'd0);
    for (int unsigned e = 0; e < 5; e++) begin
      tick();
      check($sformatf("A_addr%0d", e), 32'(read_add), 32'(addr_of(5'd31, e)));
      if (e < 3) check($sformatf("A_valid_low%0d", e), 32'(valid_out), 32'd0);
      if (e == 3) check("A_valid_first", 32'(valid_out), 32'd1);
    end
    wait_empty(30, "A_drain");
    repeat (5) tick();
    check("A_count", 32'(n_xfer), 32'd5);
    check("A_addr_stable", 32'(read_add), 32'(addr_of(5'd31, 4)));

    // B: 10 entries of page 0 with downstream stalled
    n_xfer = 0; ready_in = 1'b0; number_in = 6'd10; start = 2'b01;
    expect_page(5'd0, 10);
    tick();
    start = 2'b00;
    prev = read_add; changes = 0;
    repeat (12) begin
      tick();
      if (read_add !== prev) changes++;
      prev = read_add;
    end
    check("B_issued", 32'(changes), 32'd4);
    check("B_stall_addr", 32'(read_add), 32'(addr_of(5'd0, 3)));
    check("B_valid_held", 32'(valid_out), 32'd1);
    check("B_head", 32'(data_out), 32'(word_of_addr(addr_of(5'd0, 0))));
    ready_in = 1'b1;
    wait_empty(80, "B_drain");
    repeat (5) tick();
    check("B_count", 32'(n_xfer), 32'd10);
    check("B_final_addr", 32'(read_add), 32'(addr_of(5'd0, 9)));

    // C: zero-entry page, done timing
    prev = read_add; number_in = 6'd0; start = 2'b01;
    tick();
    start = 2'b00;
    check("C_done_e0", 32'(done), 32'd0);
    tick();
    check("C_done_e1", 32'(done), 32'd0);
    tick();
    check("C_done_e2", 32'(done), 32'd1);
    tick();
    check("C_done_e3", 32'(done), 32'd0);
    check("C_addr_hold", 32'(read_add), 32'(prev));
    check("C_no_valid", 32'(valid_out), 32'd0);

    // E: flush with FIFO non-empty
    ready_in = 1'b0; number_in = 6'd12; start = 2'b01;
    tick();
    start = 2'b00;
    repeat (8) tick();
    check("E_pre_valid", 32'(valid_out), 32'd1);
    start = 2'b10;
    tick();
    start = 2'b00;
    check("E_flush_valid", 32'(valid_out), 32'd0);
    check("E_flush_last", 32'(last_out), 32'd0);
    ready_in = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      check($sformatf("E_empty%0d", k), 32'(valid_out), 32'd0);
      if (k == 1) check("E_done_flush", 32'(done), 32'd2);
    end

    // D: page 31 after flush, truncated by a new start after 6 addresses
    n_xfer = 0; number_in = 6'd20; start = 2'b01;
    expect_page(5'd31, 6);
    tick();
    start = 2'b00;
    for (int unsigned e = 0; e < 6; e++) begin
      tick();
      check($sformatf("D_addr%0d", e), 32'(read_add), 32'(addr_of(5'd31, e)));
    end
    number_in = 6'd3; start = 2'b01;
    expect_page(5'd0, 3);
    tick();
    start = 2'b00;
    check("D_trunc_pulse", 32'(truncated), 32'd1);
    check("D_stop_issue", 32'(read_add), 32'(addr_of(5'd31, 5)));
    tick();
    check("D_trunc_end", 32'(truncated), 32'd0);
    check("D_stop_issue2", 32'(read_add), 32'(addr_of(5'd31, 5)));
    wait_empty(80, "D_drain");
    repeat (5) tick();
    check("D_count", 32'(n_xfer), 32'd9);
    check("D_new_page_addr", 32'(read_add), 32'(addr_of(5'd0, 2)));

    // F: asynchronous reset mid-readout
    ready_in = 1'b0; number_in = 6'd8; start = 2'b01;
    tick();
    start = 2'b00;
    repeat (7) tick();
    check("F_pre_valid", 32'(valid_out), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_rst("F_async");
    tick();
    reset = 1'b1;
    tick();
    check("F_exit_valid", 32'(valid_out), 32'd0);
    check("F_exit_addr", 32'(read_add), 32'd0);
    n_xfer = 0; ready_in = 1'b1; number_in = 6'd2; start = 2'b01;
    expect_page(5'd31, 2);
    tick();
    start = 2'b00;
    wait_empty(40, "F_drain");
    repeat (5) tick();
    check("F_count", 32'(n_xfer), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
